// File: rtl/bcd_to_bin_seq_if.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq_if
//  Handshake and data bundle between a requester (control unit or testbench)
//  and the sequential BCD-to-binary converter.
//  Signals (named from the converter's point of view):
//   start_i  request a conversion (sampled only while the converter is idle)
//   bcd_i    NDIG packed BCD digits, [3:0] = units digit
//   busy_o   conversion in progress (includes the done cycle)
//   done_o   one-cycle pulse, result / error flag valid
//   err_o    last accepted request held a digit > 9
//   bin_o    unsigned binary result, zero while err_o = 1
//  Modports: master = requester side, slave = converter side.
// -----------------------------------------------------------------------------
interface bcd_to_bin_seq_if #(
   parameter int NDIG = 8
);
   localparam int BW = 4 * NDIG;

   logic          start_i;
   logic [BW-1:0] bcd_i;
   logic          busy_o;
   logic          done_o;
   logic          err_o;
   logic [BW-1:0] bin_o;

   modport master (
      output start_i,
      output bcd_i,
      input  busy_o,
      input  done_o,
      input  err_o,
      input  bin_o
   );

   modport slave (
      input  start_i,
      input  bcd_i,
      output busy_o,
      output done_o,
      output err_o,
      output bin_o
   );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
//  Sequential BCD-to-binary converter using reverse double-dabble: every clock
//  the combined {bcd, bin} register is shifted right by one and each BCD digit
//  that ends up >= 8 has 3 subtracted. After BW shifts the binary register
//  holds the value of the original digits.
//  Ports:
//   clk_i   single clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     bcd_to_bin_seq_if.slave : start/bcd in, busy/done/err/bin out
//  Timing (start accepted at edge k):
//   valid digits : busy in cycles k+1 .. k+BW+1, done in cycle k+BW+1
//   bad digit    : busy and done in cycle k+1, err = 1, bin = 0
// -----------------------------------------------------------------------------
module bcd_to_bin_seq #(
   parameter int NDIG = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   bcd_to_bin_seq_if.slave  bus
);

   localparam int BW = 4 * NDIG;
   localparam int CW = $clog2(BW);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Returns 1 when any 4-bit digit of the packed value exceeds 9.
   function automatic logic has_bad_digit(input logic [BW-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

   // One reverse double-dabble step: shift the whole {bcd, bin} register right,
   // then pull every BCD digit that is now >= 8 back into range by subtracting 3
   // (a bit moving down from the next digit is worth 10/2 = 5, not 16/2 = 8).
   // Only the BCD half is corrected; the binary half just collects bits.
   function automatic logic [2*BW-1:0] shift_corr(input logic [2*BW-1:0] v);
      logic [2*BW-1:0] s;
      s = v >> 1;
      for (int i = 0; i < NDIG; i++) begin
         if (s[BW + 4*i +: 4] >= 4'd8) begin
            s[BW + 4*i +: 4] = s[BW + 4*i +: 4] - 4'd3;
         end
      end
      return s;
   endfunction

   state_t          state_q;
   logic [2*BW-1:0] sr_q;       // {bcd_reg, bin_reg}
   logic [2*BW-1:0] sr_d;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;
   logic [BW-1:0]   bin_q;
   logic            bad_s;

   // Next shift-register value and input digit validity.
   always_comb begin
      sr_d  = shift_corr(sr_q);
      bad_s = has_bad_digit(bus.bcd_i);
   end

   // Control FSM and datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         sr_q    <= {(2*BW){1'b0}};
         cnt_q   <= {CW{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         bin_q   <= {BW{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start_i) begin
                  busy_q <= 1'b1;
                  if (bad_s) begin
                     // Invalid request: report immediately, no shifting.
                     err_q   <= 1'b1;
                     bin_q   <= {BW{1'b0}};
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     sr_q    <= {bus.bcd_i, {BW{1'b0}}};
                     cnt_q   <= {CW{1'b0}};
                     err_q   <= 1'b0;
                     state_q <= S_SHIFT;
                  end
               end else begin
                  busy_q <= 1'b0;
               end
            end

            S_SHIFT: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_q == CW'(BW - 1)) begin
                  // Last shift: the freshly shifted binary half is the result.
                  bin_q   <= sr_d[BW-1:0];
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  state_q <= S_SHIFT;
               end
            end

            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;
   assign bus.err_o  = err_q;
   assign bus.bin_o  = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin_seq
//  Directed and random stimulus for bcd_to_bin_seq. The driver pushes the
//  expected {bin, err, done cycle} into a scoreboard queue at each accepted
//  start; an independent monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

   localparam int NDIG = 8;
   localparam int BW   = 4 * NDIG;

   typedef struct {
      logic [BW-1:0] bin;
      logic          err;
      int            due;
      string         name;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   bcd_to_bin_seq_if #(.NDIG(NDIG)) bus ();

   bcd_to_bin_seq #(.NDIG(NDIG)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Rising-edge counter used to measure done latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Binary-to-BCD of the display path, used to build round-trip stimulus.
   function automatic logic [BW-1:0] to_bcd(input int unsigned v);
      logic [BW-1:0] r;
      int unsigned   x;
      r = '0;
      x = v;
      for (int i = 0; i < NDIG; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Monitor: compares every done pulse against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.done_o === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check({e.name, "_bin"}, bus.bin_o, e.bin);
               check({e.name, "_err"}, BW'(bus.err_o), BW'(e.err));
               check({e.name, "_cycle"}, BW'(cyc), BW'(e.due));
               check({e.name, "_busy"}, BW'(bus.busy_o), BW'(1'b1));
            end
         end else if (sb.size() > 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done at cycle %0d", e.name, e.due);
         end
      end
   end

   // Issue one request once the converter is idle and queue its expectation.
   task automatic issue(input logic [BW-1:0] bcd, input logic [BW-1:0] exp_bin,
                        input logic exp_err, input string nm);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (bus.busy_o !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL %s_idle_wait: got busy=1 expected idle within 100 cycles", nm);
      end
      bus.start_i = 1'b1;
      bus.bcd_i   = bcd;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.bcd_i   = BW'($urandom);   // must never be re-sampled
      e.bin  = exp_bin;
      e.err  = exp_err;
      e.due  = exp_err ? cyc : cyc + BW;
      e.name = nm;
      sb.push_back(e);
      check({nm, "_busy_after_start"}, BW'(bus.busy_o), BW'(1'b1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned v;
      bus.start_i = 1'b0;
      bus.bcd_i   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", BW'(bus.busy_o), BW'(1'b0));
      check("rst_done", BW'(bus.done_o), BW'(1'b0));
      check("rst_err",  BW'(bus.err_o),  BW'(1'b0));
      check("rst_bin",  bus.bin_o, 32'h0000_0000);
      rst_n = 1'b1;

      // Directed values, hand-computed
      issue(32'h1234_5678, 32'h00BC_614E, 1'b0, "v12345678");
      issue(32'h9999_9999, 32'h05F5_E0FF, 1'b0, "v99999999");
      issue(32'h0000_0000, 32'h0000_0000, 1'b0, "v0");
      issue(32'h0000_0001, 32'h0000_0001, 1'b0, "v1");
      issue(32'h1000_0000, 32'h0098_9680, 1'b0, "v10000000");
      issue(32'h0000_0010, 32'h0000_000A, 1'b0, "v10");

      // Invalid digits, then a valid request clears err
      issue(32'h1234_567A, 32'h0000_0000, 1'b1, "bad_low");
      issue(32'hA000_0000, 32'h0000_0000, 1'b1, "bad_high");
      issue(32'h0000_0042, 32'h0000_002A, 1'b0, "v42");
      drain();
      repeat (5) @(negedge clk);
      check("hold_bin", bus.bin_o, 32'h0000_002A);
      check("hold_err", BW'(bus.err_o), BW'(1'b0));

      // Start while busy is ignored: one result, one done
      issue(32'h0000_0123, 32'h0000_007B, 1'b0, "v123_ignore");
      repeat (10) @(negedge clk);
      bus.start_i = 1'b1;
      bus.bcd_i   = 32'h9999_9999;
      @(negedge clk);
      bus.start_i = 1'b0;
      drain();
      repeat (3) @(negedge clk);

      // Reset in the middle of a conversion
      issue(32'h0000_5555, 32'h0000_15B3, 1'b0, "v5555_aborted");
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", BW'(bus.busy_o), BW'(1'b0));
      check("midrst_done", BW'(bus.done_o), BW'(1'b0));
      check("midrst_err",  BW'(bus.err_o),  BW'(1'b0));
      check("midrst_bin",  bus.bin_o, 32'h0000_0000);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'h0000_0777, 32'h0000_0309, 1'b0, "v777_after_rst");
      drain();

      // Random round-trip, back-to-back
      for (int i = 0; i < 200; i++) begin
         v = $urandom_range(99_999_999, 0);
         issue(to_bcd(v), BW'(v), 1'b0, "rand");
      end
      drain();
      repeat (40) @(negedge clk);
      check("final_queue_empty", BW'(sb.size()), BW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
